// File: rtl/opb_register_simulink2ppc.sv
// OPB slave publishing a fabric-captured 32-bit word plus a status word to the CPU.
// Define SIMULINK2PPC_HOLD_EN to keep the first unread value instead of the latest.
module opb_register_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h0108E800,
    parameter logic [31:0] C_HIGHADDR   = 32'h0108E8FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic                    Sl_xferAck,
    input  logic [31:0]             user_data_in,
    input  logic                    user_data_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic                    rnw_q;
    logic                    regsel_q;
    logic [0:C_OPB_DWIDTH-1] rdata_q;

    logic [31:0] cap_q, cap_d;
    logic        fresh_q, fresh_d;
    logic        ovr_q, ovr_d;
    logic [15:0] cnt_q, cnt_d;

    logic        hit;
    logic        start;
    logic        in_ack;
    logic        rd_data_ack;
    logic        st_wr_ack;
    logic        pending;
    logic        load;
    logic [31:0] status;

    logic unused_ok;
    assign unused_ok = ^{OPB_BE, OPB_DBus, OPB_seqAddr, C_FAMILY};

    assign hit = OPB_select
              && (OPB_ABus >= C_BASEADDR)
              && (OPB_ABus <= C_HIGHADDR);

    assign start  = (state_q == IDLE) && hit;
    assign in_ack = (state_q == ACK);

    assign rd_data_ack = in_ack &&  rnw_q && !regsel_q;
    assign st_wr_ack   = in_ack && !rnw_q &&  regsel_q;

    assign status = {cnt_q, 14'd0, ovr_q, fresh_q};

    // FSM: state register
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!OPB_select) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM: outputs; read data only drives the bus during a read ack
    always_comb begin
        Sl_xferAck = in_ack;
        Sl_DBus    = '0;
        if (in_ack && rnw_q) begin
            Sl_DBus = rdata_q;
        end
    end

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // Read data is sampled in the request cycle and presented in the ack cycle
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rnw_q    <= 1'b0;
            regsel_q <= 1'b0;
            rdata_q  <= '0;
        end else if (start) begin
            rnw_q    <= OPB_RNW;
            regsel_q <= OPB_ABus[29];
            if (!OPB_RNW) begin
                rdata_q <= '0;
            end else if (OPB_ABus[29]) begin
                rdata_q <= status;
            end else begin
                rdata_q <= cap_q;
            end
        end
    end

    // A read consuming fresh in this cycle means the new value is not an overrun
    assign pending = fresh_q && !rd_data_ack;

`ifdef SIMULINK2PPC_HOLD_EN
    assign load = user_data_valid && !pending;
`else
    assign load = user_data_valid;
`endif

    always_comb begin
        cap_d   = cap_q;
        fresh_d = fresh_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;

        if (load) begin
            cap_d = user_data_in;
        end

        if (user_data_valid) begin
            fresh_d = 1'b1;
        end else if (rd_data_ack) begin
            fresh_d = 1'b0;
        end

        if (st_wr_ack) begin
            ovr_d = 1'b0;
            cnt_d = 16'd0;
        end else if (user_data_valid && pending) begin
            ovr_d = 1'b1;
        end

        if (user_data_valid) begin
            cnt_d = cnt_d + 16'd1;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            cap_q   <= 32'd0;
            fresh_q <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            cap_q   <= cap_d;
            fresh_q <= fresh_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Bench for opb_register_simulink2ppc: directed steps plus randomized traffic
// checked against an abstract register model.
module tb_opb_register_simulink2ppc;

`ifdef SIMULINK2PPC_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    localparam logic [31:0] A_DATA = 32'h0108E800;
    localparam logic [31:0] A_STAT = 32'h0108E804;

    logic        clk;
    logic        rst_n;
    logic [31:0] abus;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rnw;
    logic        sel;
    logic        seq;
    logic [31:0] sl_dbus;
    logic        sl_err;
    logic        sl_retry;
    logic        sl_tout;
    logic        xack;
    logic [31:0] udata;
    logic        uvalid;

    int checks = 0;
    int fails  = 0;

    // Reference model state
    logic [31:0] m_data;
    bit          m_fresh;
    bit          m_ovr;
    int          m_cnt;

    opb_register_simulink2ppc dut (
        .OPB_Clk        (clk),
        .OPB_Rst_n      (rst_n),
        .OPB_ABus       (abus),
        .OPB_BE         (be),
        .OPB_DBus       (wdata),
        .OPB_RNW        (rnw),
        .OPB_select     (sel),
        .OPB_seqAddr    (seq),
        .Sl_DBus        (sl_dbus),
        .Sl_errAck      (sl_err),
        .Sl_retry       (sl_retry),
        .Sl_toutSup     (sl_tout),
        .Sl_xferAck     (xack),
        .user_data_in   (udata),
        .user_data_valid(uvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [15:0] c;
        c = 16'(m_cnt);
        return {c, 14'd0, m_ovr, m_fresh};
    endfunction

    task automatic m_reset();
        m_data  = 32'd0;
        m_fresh = 1'b0;
        m_ovr   = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock of model time: optional valid, data-read ack, status-write ack
    task automatic m_step(input bit vld, input logic [31:0] vd,
                          input bit rd_data, input bit st_wr);
        bit unread;
        unread = m_fresh && !rd_data;
        if (st_wr) begin
            m_ovr = 1'b0;
            m_cnt = 0;
        end
        if (vld) begin
            if (unread && !st_wr) m_ovr = 1'b1;
            m_cnt = (m_cnt + 1) % 65536;
            if (!(HOLD && unread)) m_data = vd;
            m_fresh = 1'b1;
        end else if (rd_data) begin
            m_fresh = 1'b0;
        end
    endtask

    task automatic pulse(input logic [31:0] d);
        @(posedge clk); #1;
        uvalid = 1'b1;
        udata  = d;
        @(posedge clk); #1;
        uvalid = 1'b0;
        m_step(1'b1, d, 1'b0, 1'b0);
    endtask

    // Full bus transfer; optional valid lands in the ack cycle
    task automatic xfer(input string tag, input logic [31:0] addr,
                        input bit r, input bit vld,
                        input logic [31:0] vd, output logic [31:0] rd);
        int  n;
        bit  got;
        @(posedge clk); #1;
        sel   = 1'b1;
        abus  = addr;
        rnw   = r;
        wdata = $urandom;
        got   = 1'b0;
        n     = 0;
        while (!got && n < 8) begin
            @(posedge clk); #1;
            n++;
            if (xack) got = 1'b1;
        end
        chk({tag, "_lat"}, n, 1);
        rd = sl_dbus;
        if (!r) chk({tag, "_wdbus"}, sl_dbus, 0);
        if (vld) begin
            uvalid = 1'b1;
            udata  = vd;
        end
        sel = 1'b0;
        @(posedge clk); #1;
        uvalid = 1'b0;
        chk({tag, "_ack1"}, xack, 0);
        @(posedge clk); #1;
        m_step(vld, vd, r && !addr[2], !r && addr[2]);
    endtask

    logic [31:0] rd;
    logic [31:0] exp_v;
    logic [31:0] d;
    int          nack;
    logic [31:0] dor;

    initial begin
        rst_n  = 1'b0;
        abus   = 32'd0;
        be     = 4'hF;
        wdata  = 32'd0;
        rnw    = 1'b0;
        sel    = 1'b0;
        seq    = 1'b0;
        udata  = 32'd0;
        uvalid = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", xack, 0);
        chk("rst_dbus", sl_dbus, 0);
        chk("rst_err", {sl_err, sl_retry, sl_tout}, 0);
        rst_n = 1'b1;

        // Step 1: reset values
        xfer("r_data0", A_DATA, 1, 0, 0, rd);
        chk("data0", rd, 32'h0);
        xfer("r_stat0", A_STAT, 1, 0, 0, rd);
        chk("stat0", rd, 32'h0);

        // Step 2: single capture
        pulse(32'hDEADBEEF);
        xfer("r_s2a", A_STAT, 1, 0, 0, rd);
        chk("stat2a", rd, 32'h00010001);
        xfer("r_d2", A_DATA, 1, 0, 0, rd);
        chk("data2", rd, 32'hDEADBEEF);
        xfer("r_s2b", A_STAT, 1, 0, 0, rd);
        chk("stat2b", rd, 32'h00010000);

        // Step 3: overrun
        xfer("w_clr3", A_STAT, 0, 0, 0, rd);
        pulse(32'h11);
        pulse(32'h22);
        xfer("r_s3", A_STAT, 1, 0, 0, rd);
        chk("stat3", rd, 32'h00020003);
        exp_v = HOLD ? 32'h11 : 32'h22;
        xfer("r_d3", A_DATA, 1, 0, 0, rd);
        chk("data3", rd, exp_v);
        xfer("r_s3b", A_STAT, 1, 0, 0, rd);
        chk("stat3b", rd, 32'h00020002);

        // Step 4: status clear, alone and racing a valid
        xfer("w_clr4", A_STAT, 0, 0, 0, rd);
        xfer("r_s4", A_STAT, 1, 0, 0, rd);
        chk("stat4", rd, 32'h0);
        pulse(32'h77);
        pulse(32'h78);
        xfer("w_clr4v", A_STAT, 0, 1, 32'hA5A5A5A5, rd);
        xfer("r_s4v", A_STAT, 1, 0, 0, rd);
        chk("stat4v", rd, 32'h00010001);
        exp_v = HOLD ? 32'h77 : 32'hA5A5A5A5;
        xfer("r_d4", A_DATA, 1, 1, 32'h5A5A5A5A, rd);
        chk("data4_race", rd, exp_v);
        xfer("r_s4r", A_STAT, 1, 0, 0, rd);
        chk("stat4_race", rd, 32'h00020001);
        xfer("r_d4b", A_DATA, 1, 0, 0, rd);
        chk("data4b", rd, 32'h5A5A5A5A);
        xfer("w_data", A_DATA, 0, 0, 0, rd);
        xfer("r_d4c", A_DATA, 1, 0, 0, rd);
        chk("data_wr_noeff", rd, 32'h5A5A5A5A);

        // Step 5: long select, window edges
        @(posedge clk); #1;
        sel = 1'b1; abus = A_STAT; rnw = 1'b1;
        nack = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (xack) nack++;
        end
        sel = 1'b0;
        repeat (2) @(posedge clk);
        chk("long_sel", nack, 1);
        xfer("r_top", 32'h0108E8FC, 1, 0, 0, rd);
        chk("top_alias", rd, m_status());
        foreach (d[i]) d[i] = 1'b0;
        d = 32'h0108E900;
        repeat (2) begin
            @(posedge clk); #1;
            sel = 1'b1; abus = d; rnw = 1'b1;
            nack = 0; dor = 32'd0;
            repeat (5) begin
                @(posedge clk); #1;
                if (xack) nack++;
                dor = dor | sl_dbus;
            end
            sel = 1'b0;
            repeat (2) @(posedge clk);
            chk("oor_ack", nack, 0);
            chk("oor_dbus", dor, 0);
            d = 32'h0108E7FC;
        end

        // Step 6: reset inside the ack cycle
        pulse(32'h1234);
        @(posedge clk); #1;
        sel = 1'b1; abus = A_STAT; rnw = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_ack", xack, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ack", xack, 0);
        chk("rst_mid_dbus", sl_dbus, 0);
        sel = 1'b0;
        #2;
        rst_n = 1'b1;
        m_reset();
        xfer("r_s6", A_STAT, 1, 0, 0, rd);
        chk("stat6", rd, 32'h0);
        xfer("r_d6", A_DATA, 1, 0, 0, rd);
        chk("data6", rd, 32'h0);

        // Counter wrap: valid held for 65537 cycles
        xfer("w_clrw", A_STAT, 0, 0, 0, rd);
        @(posedge clk); #1;
        uvalid = 1'b1;
        udata  = 32'hC0DE0001;
        repeat (65537) @(posedge clk);
        #1;
        uvalid = 1'b0;
        for (int i = 0; i < 65537; i++) m_step(1'b1, 32'hC0DE0001, 1'b0, 1'b0);
        xfer("r_wrap", A_STAT, 1, 0, 0, rd);
        chk("wrap", rd, 32'h00010003);

        // Randomized traffic against the model
        for (int k = 0; k < 60; k++) begin
            int  op;
            bit  v;
            op = $urandom_range(0, 4);
            v  = 1'($urandom_range(0, 1));
            d  = $urandom;
            case (op)
                0: pulse(d);
                1: begin
                    exp_v = m_data;
                    xfer("rnd_rd", A_DATA, 1, v, d, rd);
                    chk("rnd_data", rd, exp_v);
                end
                2: begin
                    exp_v = m_status();
                    xfer("rnd_rs", A_STAT, 1, v, d, rd);
                    chk("rnd_stat", rd, exp_v);
                end
                3: xfer("rnd_ws", A_STAT, 0, v, d, rd);
                default: xfer("rnd_wd", A_DATA, 0, v, d, rd);
            endcase
        end
        exp_v = m_status();
        xfer("fin_s", A_STAT, 1, 0, 0, rd);
        chk("fin_stat", rd, exp_v);
        exp_v = m_data;
        xfer("fin_d", A_DATA, 1, 0, 0, rd);
        chk("fin_data", rd, exp_v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
